// File: rtl/pwm_pkg.sv
// Shared types and defaults for the tick-driven PWM generator.
package pwm_pkg;

  localparam int DEFAULT_CNT_WIDTH = 8;

  typedef enum logic {
    PWM_IDLE = 1'b0,
    PWM_RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Turns each rising edge of a clk-synchronous slow signal into a one-cycle pulse.
module tick_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise_pulse
);

  logic sig_prev_q;

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) sig_prev_q <= 1'b0;
    else        sig_prev_q <= sig_in;
  end

  assign rise_pulse = sig_in & ~sig_prev_q;

endmodule

// File: rtl/tick_pwm_generator.sv
// Tick-counting PWM with double-buffered period/duty applied at period boundaries.
// Optional PWM_COMPLEMENT_EN adds a registered complementary output pwm_out_n.
module tick_pwm_generator
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_in,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] duty,
  input  logic                 update,
  output logic                 pwm_out,
  output logic                 period_done,
  output logic                 running
`ifdef PWM_COMPLEMENT_EN
  ,
  output logic                 pwm_out_n
`endif
);

  pwm_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [CNT_WIDTH-1:0] act_period_q, act_period_d;
  logic [CNT_WIDTH-1:0] act_duty_q, act_duty_d;
  logic [CNT_WIDTH-1:0] pend_period_q, pend_period_d;
  logic [CNT_WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 pwm_q, pwm_d;
  logic                 done_q, done_d;
  logic                 tick;

  tick_edge_detect u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (tick_in),
    .rise_pulse (tick)
  );

  always_comb begin
    // NOTE: every next-state signal gets its current value first, so no path can infer a latch.
    state_d       = state_q;
    counter_d     = counter_q;
    act_period_d  = act_period_q;
    act_duty_d    = act_duty_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pend_valid_d  = pend_valid_q;
    done_d        = 1'b0;

    if (update) begin
      pend_period_d = period;
      pend_duty_d   = duty;
      pend_valid_d  = 1'b1;
    end

    unique case (state_q)
      PWM_IDLE: begin
        if (pend_valid_q) begin
          act_period_d = pend_period_q;
          act_duty_d   = pend_duty_q;
          if (!update) pend_valid_d = 1'b0;
        end
        if (enable && (act_period_q != '0)) begin
          state_d   = PWM_RUN;
          counter_d = '0;
        end
      end
      PWM_RUN: begin
        if (!enable || (act_period_q == '0)) begin
          state_d   = PWM_IDLE;
          counter_d = '0;
        end else if (tick) begin
          if (counter_q == act_period_q - CNT_WIDTH'(1)) begin
            counter_d = '0;
            done_d    = 1'b1;
            // A strobe coinciding with the wrap bypasses the buffer so it lands in this period.
            if (update) begin
              act_period_d = period;
              act_duty_d   = duty;
              pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
              act_period_d = pend_period_q;
              act_duty_d   = pend_duty_q;
              pend_valid_d = 1'b0;
            end
          end else begin
            counter_d = counter_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = PWM_IDLE;
    endcase

    pwm_d = (state_d == PWM_RUN) && (counter_d < act_duty_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= PWM_IDLE;
      counter_q     <= '0;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_valid_q  <= 1'b0;
      pwm_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      act_period_q  <= act_period_d;
      act_duty_q    <= act_duty_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_valid_q  <= pend_valid_d;
      pwm_q         <= pwm_d;
      done_q        <= done_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign running     = (state_q == PWM_RUN);

`ifdef PWM_COMPLEMENT_EN
  logic pwm_n_q, pwm_n_d;

  assign pwm_n_d = (state_d == PWM_RUN) && !pwm_d;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_n_q <= 1'b0;
    else        pwm_n_q <= pwm_n_d;
  end

  assign pwm_out_n = pwm_n_q;
`endif

endmodule

// File: tb/tb_tick_pwm_generator.sv
// Directed bench for tick_pwm_generator; outputs are sampled 1ns after each rising clk edge.
module tb_tick_pwm_generator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_in = 1'b0;
  logic         enable = 1'b0;
  logic         update = 1'b0;
  logic [W-1:0] period = '0;
  logic [W-1:0] duty = '0;
  logic         pwm_out, period_done, running;
`ifdef PWM_COMPLEMENT_EN
  logic         pwm_out_n;
`endif

  int checks = 0;
  int errors = 0;

  tick_pwm_generator #(.CNT_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_in     (tick_in),
    .enable      (enable),
    .period      (period),
    .duty        (duty),
    .update      (update),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .running     (running)
`ifdef PWM_COMPLEMENT_EN
    ,
    .pwm_out_n   (pwm_out_n)
`endif
  );

  always #5 clk = ~clk;

  // {pwm_out, period_done, running}
  function automatic logic [2:0] outs();
    return {pwm_out, period_done, running};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick_in = 1'b0; enable = 1'b0; update = 1'b0; period = '0; duty = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic start_pwm(input logic [W-1:0] p, input logic [W-1:0] d);
    period = p; duty = d; update = 1'b1;
    step();
    update = 1'b0;
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1; update = 1'b1; period = 8'd4; duty = 8'd2; tick_in = ~tick_in;
      step();
      checks++;
      if (outs() !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected 000", i, outs());
      end
    end
    // With no update since reset the active period is 0, so enable alone must not start.
    rst_n = 1'b1; update = 1'b0; tick_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (outs() !== 3'b000) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %b expected 000", i, outs());
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_basic();
    int k = 0;
    logic [2:0] exp;
    do_reset();
    start_pwm(8'd4, 8'd1);
    checks++;
    if (outs() !== 3'b101) begin
      errors++;
      $display("FAIL basic_start: got %b expected 101", outs());
    end
    for (int i = 0; i < 32; i++) begin
      tick_in = (i % 4 == 0);
      step();
      if (i % 4 == 0) k++;
      exp = {((k % 4) < 1), ((i % 4 == 0) && (k % 4 == 0)), 1'b1};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL basic_clk[%0d]: got %b expected %b", i, outs(), exp);
      end
    end
    tick_in = 1'b0;
  endtask

  task automatic test_reload();
    logic [0:10] exp_pwm = 11'b00111111001;
    logic [0:10] exp_done = 11'b00100000001;
    do_reset();
    start_pwm(8'd4, 8'd2);
    tick_once();
    step();
    period = 8'd8; duty = 8'd6; update = 1'b1;
    step();
    update = 1'b0;
    checks++;
    if (outs() !== 3'b101) begin
      errors++;
      $display("FAIL reload_pending: got %b expected 101", outs());
    end
    for (int i = 0; i < 11; i++) begin
      tick_once();
      checks++;
      if (outs() !== {exp_pwm[i], exp_done[i], 1'b1}) begin
        errors++;
        $display("FAIL reload_tick[%0d]: got %b expected %b", i + 2, outs(), {exp_pwm[i], exp_done[i], 1'b1});
      end
      step();
      checks++;
      if (outs() !== {exp_pwm[i], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reload_hold[%0d]: got %b expected %b", i + 2, outs(), {exp_pwm[i], 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_duty_limits();
    logic [2:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      start_pwm(8'd4, (pass == 0) ? 8'd0 : 8'd10);
      for (int i = 1; i <= 12; i++) begin
        tick_once();
        exp = {(pass == 1), (i % 4 == 0), 1'b1};
        checks++;
        if (outs() !== exp) begin
          errors++;
          $display("FAIL duty_limit[p%0d t%0d]: got %b expected %b", pass, i, outs(), exp);
        end
        step();
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [0:3] exp_pwm = 4'b1001;
    logic [0:3] exp_done = 4'b0001;
    do_reset();
    start_pwm(8'd4, 8'd2);
    tick_once();
    step();
    tick_once();
    checks++;
    if (outs() !== 3'b001) begin
      errors++;
      $display("FAIL drop_at_cnt2: got %b expected 001", outs());
    end
`ifdef PWM_COMPLEMENT_EN
    checks++;
    if (pwm_out_n !== 1'b1) begin
      errors++;
      $display("FAIL comp_run_low: got %b expected 1", pwm_out_n);
    end
`endif
    step();
    enable = 1'b0; tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    checks++;
    if (outs() !== 3'b000) begin
      errors++;
      $display("FAIL drop_disable: got %b expected 000", outs());
    end
`ifdef PWM_COMPLEMENT_EN
    checks++;
    if (pwm_out_n !== 1'b0) begin
      errors++;
      $display("FAIL comp_idle: got %b expected 0", pwm_out_n);
    end
`endif
    step();
    enable = 1'b1;
    step();
    checks++;
    if (outs() !== 3'b101) begin
      errors++;
      $display("FAIL drop_reenable: got %b expected 101", outs());
    end
    for (int i = 0; i < 4; i++) begin
      tick_once();
      checks++;
      if (outs() !== {exp_pwm[i], exp_done[i], 1'b1}) begin
        errors++;
        $display("FAIL drop_restart[%0d]: got %b expected %b", i, outs(), {exp_pwm[i], exp_done[i], 1'b1});
      end
      step();
    end
  endtask

  task automatic test_hold_high();
    logic [0:2] exp_pwm = 3'b001;
    logic [0:2] exp_done = 3'b001;
    do_reset();
    start_pwm(8'd4, 8'd1);
    tick_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (outs() !== 3'b001) begin
        errors++;
        $display("FAIL hold_high[%0d]: got %b expected 001", i, outs());
      end
`ifdef PWM_COMPLEMENT_EN
      checks++;
      if (pwm_out_n !== ~pwm_out) begin
        errors++;
        $display("FAIL comp_hold[%0d]: got %b expected %b", i, pwm_out_n, ~pwm_out);
      end
`endif
    end
    tick_in = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      tick_once();
      checks++;
      if (outs() !== {exp_pwm[i], exp_done[i], 1'b1}) begin
        errors++;
        $display("FAIL hold_after[%0d]: got %b expected %b", i, outs(), {exp_pwm[i], exp_done[i], 1'b1});
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_pwm(8'd4, 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick_once();
      checks++;
      if (outs() !== 3'b001) begin
        errors++;
        $display("FAIL b2b_pre[%0d]: got %b expected 001", i, outs());
      end
      step();
    end
    tick_in = 1'b1; update = 1'b1; period = 8'd2; duty = 8'd2;
    step();
    tick_in = 1'b0; update = 1'b0;
    checks++;
    if (outs() !== 3'b111) begin
      errors++;
      $display("FAIL b2b_wrap: got %b expected 111", outs());
    end
    step();
    tick_once();
    checks++;
    if (outs() !== 3'b101) begin
      errors++;
      $display("FAIL b2b_new_duty: got %b expected 101", outs());
    end
    step();
    tick_once();
    checks++;
    if (outs() !== 3'b111) begin
      errors++;
      $display("FAIL b2b_new_period: got %b expected 111", outs());
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_duty_limits();
    test_enable_drop();
    test_hold_high();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
